// File: rtl/proc_array_feeder.sv
// proc_array_feeder: west-edge driver for a row of GF(2^m) systolic elements.
// Encodes command mode into op/gauss_op and emits row beats with a per-column triangular skew.
`default_nettype none

module proc_array_feeder #(
  parameter int GF_BIT       = 4,
  parameter int OP_CODE_LEN  = 4,
  parameter int NUM_PROC_COL = 3,
  parameter int LEN_W        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [1:0]                     i_cmd_mode,
  input  logic [LEN_W-1:0]               i_cmd_len,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [NUM_PROC_COL*GF_BIT-1:0] i_in_data,
  input  logic [GF_BIT-1:0]              i_in_dataB,
  output logic [NUM_PROC_COL-1:0]        o_start_out,
  output logic [2*NUM_PROC_COL-1:0]      o_gauss_op_out,
  output logic [OP_CODE_LEN-1:0]         o_op_out,
  output logic [NUM_PROC_COL*GF_BIT-1:0] o_data_out,
  output logic [GF_BIT-1:0]              o_dataB_out,
  output logic [NUM_PROC_COL-1:0]        o_lane_valid,
  output logic                           o_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int DW = $clog2(NUM_PROC_COL + 1);

  logic [1:0]             r_state;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_cnt;
  logic [DW-1:0]          r_dcnt;
  logic                   r_first;
  logic [OP_CODE_LEN-1:0] r_op;
  logic [1:0]             r_gop;
  logic [GF_BIT-1:0]      r_dataB;

  logic [OP_CODE_LEN-1:0] w_op_enc;
  logic [1:0]             w_gop_enc;
  logic                   w_xfer;

  always_comb begin
    w_op_enc  = OP_CODE_LEN'(4'b1000);
    w_gop_enc = 2'b00;
    case (i_cmd_mode)
      2'd0: begin w_op_enc = OP_CODE_LEN'(4'b1000); w_gop_enc = 2'b00; end
      2'd1: begin w_op_enc = OP_CODE_LEN'(4'b1010); w_gop_enc = 2'b11; end
      2'd2: begin w_op_enc = OP_CODE_LEN'(4'b1110); w_gop_enc = 2'b10; end
      default: begin w_op_enc = OP_CODE_LEN'(4'b1110); w_gop_enc = 2'b01; end
    endcase
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_in_ready  = (r_state == S_STREAM);
  assign o_done      = (r_state == S_DONE);
  assign o_op_out    = r_op;
  assign o_dataB_out = r_dataB;
  assign w_xfer      = i_in_valid & o_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_first <= 1'b0;
      r_op    <= '0;
      r_gop   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_op    <= w_op_enc;
            r_gop   <= w_gop_enc;
            r_len   <= i_cmd_len;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_first <= 1'b1;
            r_state <= (i_cmd_len == '0) ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            r_first <= 1'b0;
            r_cnt   <= r_cnt + LEN_W'(1);
            if (r_cnt == r_len - LEN_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // One bubble cycle per lane lets the deepest lane flush its last beat.
          if (r_dcnt == DW'(NUM_PROC_COL - 1)) r_state <= S_DONE;
          else r_dcnt <= r_dcnt + DW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dataB <= '0;
    else     r_dataB <= w_xfer ? i_in_dataB : '0;
  end

  genvar c;
  generate
    for (c = 0; c < NUM_PROC_COL; c++) begin : g_lane
      logic [GF_BIT-1:0] r_d [0:c];
      logic [1:0]        r_g [0:c];
      logic              r_s [0:c];
      logic              r_v [0:c];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k <= c; k++) begin
            r_d[k] <= '0;
            r_g[k] <= 2'b00;
            r_s[k] <= 1'b0;
            r_v[k] <= 1'b0;
          end
        end else begin
          r_d[0] <= w_xfer ? i_in_data[c*GF_BIT +: GF_BIT] : '0;
          r_g[0] <= w_xfer ? r_gop : 2'b00;
          r_s[0] <= w_xfer & r_first;
          r_v[0] <= w_xfer;
          for (int k = 1; k <= c; k++) begin
            r_d[k] <= r_d[k-1];
            r_g[k] <= r_g[k-1];
            r_s[k] <= r_s[k-1];
            r_v[k] <= r_v[k-1];
          end
        end
      end

      assign o_data_out[c*GF_BIT +: GF_BIT] = r_d[c];
      assign o_gauss_op_out[2*c +: 2]       = r_g[c];
      assign o_start_out[c]                 = r_s[c];
      assign o_lane_valid[c]                = r_v[c];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_proc_array_feeder.sv
// tb_proc_array_feeder: scoreboard bench; stimulus pushes expected lane beats and done cycles,
// a negedge monitor pops and compares whenever the DUT presents them.
`default_nettype none

module tb_proc_array_feeder;
  localparam int GF = 4;
  localparam int OPL = 4;
  localparam int N = 3;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic [LW-1:0] cmd_len = '0;
  logic in_valid = 1'b0;
  logic [N*GF-1:0] in_data = '0;
  logic [GF-1:0] in_dataB = '0;
  logic cmd_ready, in_ready, done;
  logic [N-1:0] start_out, lane_valid;
  logic [2*N-1:0] gauss_op_out;
  logic [OPL-1:0] op_out;
  logic [N*GF-1:0] data_out;
  logic [GF-1:0] dataB_out;

  proc_array_feeder #(.GF_BIT(GF), .OP_CODE_LEN(OPL), .NUM_PROC_COL(N), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_mode(cmd_mode), .i_cmd_len(cmd_len),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data), .i_in_dataB(in_dataB),
    .o_start_out(start_out), .o_gauss_op_out(gauss_op_out), .o_op_out(op_out),
    .o_data_out(data_out), .o_dataB_out(dataB_out), .o_lane_valid(lane_valid), .o_done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic       s;
    logic [1:0] g;
    logic [3:0] d;
    logic [3:0] b;
  } item_t;

  item_t q0[$], q1[$], q2[$];
  int    qdone[$];

  logic [11:0] rows [8];
  logic [3:0]  bs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] op_of(input logic [1:0] m);
    case (m)
      2'd0: op_of = 4'b1000;
      2'd1: op_of = 4'b1010;
      default: op_of = 4'b1110;
    endcase
  endfunction

  function automatic logic [1:0] gop_of(input logic [1:0] m);
    case (m)
      2'd0: gop_of = 2'b00;
      2'd1: gop_of = 2'b11;
      2'd2: gop_of = 2'b10;
      default: gop_of = 2'b01;
    endcase
  endfunction

  task automatic push_lane(input int c, input item_t e);
    case (c)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Monitor: every presented beat must match the head of its lane queue.
  item_t m_e;
  bit    m_have;
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        if (lane_valid[c]) begin
          m_have = 1'b0;
          case (c)
            0: if (q0.size() > 0) begin m_e = q0.pop_front(); m_have = 1'b1; end
            1: if (q1.size() > 0) begin m_e = q1.pop_front(); m_have = 1'b1; end
            default: if (q2.size() > 0) begin m_e = q2.pop_front(); m_have = 1'b1; end
          endcase
          checks++;
          if (!m_have) begin
            failures++;
            $display("FAIL lane_unexpected lane=%0d got valid=1 exp valid=0 cyc=%0d", c, cyc);
          end else begin
            chk($sformatf("lane%0d_cycle", c), cyc, m_e.cyc);
            chk($sformatf("lane%0d_start", c), start_out[c], m_e.s);
            chk($sformatf("lane%0d_gop", c), gauss_op_out[2*c +: 2], m_e.g);
            chk($sformatf("lane%0d_data", c), data_out[c*GF +: GF], m_e.d);
            if (c == 0) chk("dataB", dataB_out, m_e.b);
          end
        end else begin
          chk($sformatf("lane%0d_bubble", c),
              {start_out[c], gauss_op_out[2*c +: 2], data_out[c*GF +: GF]}, 32'h0);
        end
      end
      if (done) begin
        checks++;
        if (qdone.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected got=1 exp=0 cyc=%0d", cyc);
        end else begin
          chk("done_cycle", cyc, qdone.pop_front());
        end
      end else if (qdone.size() > 0 && cyc > qdone[0]) begin
        checks++;
        failures++;
        $display("FAIL done_missing got=0 exp_cyc=%0d cyc=%0d", qdone[0], cyc);
        void'(qdone.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] mode, input int len);
    int n;
    int t0;
    n = 0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_len   = LW'(len);
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("cmd_ready_timeout", cmd_ready, 1);
    t0 = cyc;
    tick();
    cmd_valid = 1'b0;
    chk("op_out", op_out, op_of(mode));
    if (len == 0) begin
      qdone.push_back(t0 + N + 1);
      chk("len0_in_ready", in_ready, 0);
    end
  endtask

  // Offers nbeats rows; one bubble is inserted before beat stall_at (-1: none).
  task automatic stream(input logic [1:0] mode, input int nbeats, input int stall_at, input bit last);
    item_t e;
    int t;
    t = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        chk("in_ready_stall", in_ready, 1);
        tick();
      end
      in_valid = 1'b1;
      in_data  = rows[i];
      in_dataB = bs[i];
      chk("in_ready", in_ready, 1);
      t = cyc;
      for (int c = 0; c < N; c++) begin
        e.cyc = t + 1 + c;
        e.s   = (i == 0);
        e.g   = gop_of(mode);
        e.d   = rows[i][c*GF +: GF];
        e.b   = bs[i];
        push_lane(c, e);
      end
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    in_dataB = '0;
    if (last) begin
      qdone.push_back(t + N + 1);
      chk("in_ready_after_last", in_ready, 0);
    end
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while ((qdone.size() > 0 || q0.size() > 0 || q1.size() > 0 || q2.size() > 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_done_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;

    // Idle after reset: everything quiet for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      chk("rst_outputs", {start_out, gauss_op_out, op_out, data_out, dataB_out, lane_valid, done}, 0);
      chk("rst_ready", {cmd_ready, in_ready}, 2'b10);
      tick();
    end

    // MUL_MAT len 4, no stalls.
    rows[0] = 12'h123; rows[1] = 12'h456; rows[2] = 12'h789; rows[3] = 12'hABC;
    bs[0] = 4'h1; bs[1] = 4'h2; bs[2] = 4'h4; bs[3] = 4'h8;
    issue_cmd(2'd0, 4);
    stream(2'd0, 4, -1, 1'b1);
    wait_done();
    chk("op_hold_idle", op_out, 4'b1000);

    // GAUSS_ADD len 3 with a bubble before the second beat.
    rows[0] = 12'hF0E; rows[1] = 12'h5A3; rows[2] = 12'h001;
    bs[0] = 4'h7; bs[1] = 4'hC; bs[2] = 4'h3;
    issue_cmd(2'd2, 3);
    stream(2'd2, 3, 1, 1'b1);
    wait_done();

    // EVAL with zero beats.
    issue_cmd(2'd1, 0);
    wait_done();
    chk("eval_op_hold", op_out, 4'b1010);

    // Back-to-back GAUSS_LOAD then EVAL.
    rows[0] = 12'h9E2; rows[1] = 12'h3B7;
    bs[0] = 4'h5; bs[1] = 4'hA;
    issue_cmd(2'd3, 2);
    stream(2'd3, 2, -1, 1'b1);
    wait_done();
    chk("cmd_ready_after_done", cmd_ready, 1);
    rows[0] = 12'h4D1; rows[1] = 12'hE68;
    bs[0] = 4'hF; bs[1] = 4'h6;
    issue_cmd(2'd1, 2);
    stream(2'd1, 2, -1, 1'b1);
    wait_done();

    // Reset in the middle of a 5-beat MUL_MAT stream.
    rows[0] = 12'h111; rows[1] = 12'h222; rows[2] = 12'h333; rows[3] = 12'h444; rows[4] = 12'h555;
    issue_cmd(2'd0, 5);
    stream(2'd0, 2, -1, 1'b0);
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); qdone.delete();
    @(negedge clk);
    chk("midrst_outputs", {start_out, gauss_op_out, op_out, data_out, dataB_out, lane_valid, done}, 0);
    chk("midrst_ready", {cmd_ready, in_ready}, 2'b10);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Fresh command after the reset.
    rows[0] = 12'hC5A; rows[1] = 12'h0F3;
    bs[0] = 4'h9; bs[1] = 4'hB;
    issue_cmd(2'd2, 2);
    stream(2'd2, 2, -1, 1'b1);
    wait_done();
    tick(); tick();

    chk("leftover_expected", q0.size() + q1.size() + q2.size() + qdone.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/proc_array_feeder.md
# proc_array_feeder

Drives the west edge of one tile row of GF(2^GF_BIT) systolic processing elements. It accepts a command (mode, beat count) and a stream of row vectors, encodes mode into op/gauss_op codes, and asserts start on the first beat. Each column lane is emitted with a triangular skew (column c delayed c cycles), matching the one-cycle data_out register of each element. It is the transmitting end of the element's start/op/gauss_op/data protocol.

## Interface
- GF_BIT, 4, field element width (4 or 8)
- OP_CODE_LEN, 4, op code width
- NUM_PROC_COL, 3, column lanes driven (≥1)
- LEN_W, 8, width of beat counter
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  2  0 MUL_MAT, 1 EVAL, 2 GAUSS_ADD, 3 GAUSS_LOAD
- cmd_len  in  LEN_W  number of beats (0 legal)
- in_valid  in  1  row vector offered
- in_ready  out  1  high only in STREAM
- in_data  in  NUM_PROC_COL*GF_BIT  lane c = bits [c*GF_BIT +: GF_BIT]
- in_dataB  in  GF_BIT  multiplier operand for the row
- start_out  out  NUM_PROC_COL  per-lane start
- gauss_op_out  out  2*NUM_PROC_COL  per-lane gauss_op
- op_out  out  OP_CODE_LEN  unskewed op of active command
- data_out  out  NUM_PROC_COL*GF_BIT  per-lane data
- dataB_out  out  GF_BIT  operand, aligned with lane 0
- lane_valid  out  NUM_PROC_COL  per-lane real-beat flag
- done  out  1  one-cycle completion pulse

## Operation
- Mode encoding (latched at cmd accept): MUL_MAT op 4'b1000 / gauss 2'b00; EVAL 4'b1010 / 2'b11; GAUSS_ADD 4'b1110 / 2'b10; GAUSS_LOAD 4'b1110 / 2'b01. For OP_CODE_LEN>4, codes are zero-extended.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch mode and len, set first flag, and go to STREAM (or to DRAIN if cmd_len=0).
- STREAM: in_ready=1. A beat transfers when in_valid&in_ready. The first transferred beat carries start=1; all later beats carry start=0. After beat number len, go to DRAIN.
- Stall (STREAM, in_valid=0): inject a bubble: lane_valid=0, start=0, gauss_op=2'b00 (pass), data=0. The skew pipeline never freezes.
- DRAIN: count NUM_PROC_COL cycles of bubbles, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Skew: lane 0 is registered once. Lane c passes through c additional registers. start, gauss_op, data and lane_valid of a lane travel together. dataB_out is aligned with lane 0.
- op_out holds the latched op from cmd accept until the next accept. In IDLE it shows the last command's op.
- No arithmetic is performed. Data is passed bit-exact.

## Timing
- Reset: state IDLE. All skew registers, start_out, gauss_op_out, op_out, data_out, dataB_out, lane_valid and done are 0. cmd_ready=1 and in_ready=0 are combinational from state.
- A beat accepted in cycle t appears on lane c in cycle t+1+c.
- Command accepted in cycle t0 → state is STREAM from t0+1.
- If the last beat is accepted in cycle tl, DRAIN covers tl+1 … tl+NUM_PROC_COL and done is high in tl+NUM_PROC_COL+1. The last lane emits its final beat in tl+NUM_PROC_COL, so done follows it by one cycle.
- cmd_len=0: DRAIN starts at t0+1, done in t0+NUM_PROC_COL+1, and no lane_valid is ever asserted.
- cmd_valid outside IDLE is ignored (cmd_ready=0). in_valid outside STREAM is ignored.
- Back-to-back: a new command can be accepted in the cycle after done. Beats of consecutive commands never overlap in any lane.
- Reset mid-operation clears the skew pipeline immediately. Partial beats are dropped and no done is issued.
- Throughput: one beat per cycle with in_valid held high.

## Test plan
- Reset then idle → all outputs 0, cmd_ready=1, in_ready=0, no done for 20 cycles.
- MUL_MAT, len=4, rows 0x123,0x456,0x789,0xABC, no stalls (accepted t=1..4) → lane 0 data 3,6,9,C at t=2..5; lane 2 data 1,4,7,A at t=4..7; start only on first beat per lane; gauss_op 00; op_out 4'b1000; done at t=8.
- GAUSS_ADD, len=3, in_valid low on the 2nd offer → one bubble (lane_valid=0, gauss_op 00, data 0) skewed across lanes; three valid beats with gauss_op 10; done 4 cycles after the third beat.
- cmd_len=0 in EVAL → no lane_valid, op_out 4'b1010, done exactly NUM_PROC_COL+1 cycles after accept.
- Back-to-back GAUSS_LOAD len=2 then EVAL len=2 → second cmd_ready one cycle after the first done; lane streams do not interleave; start asserted once per command.
- Assert rst during STREAM after 2 of 5 beats → outputs 0 next cycle, state IDLE, no done; a fresh command then runs normally.
